regxfer_seq: RTL and testbench

REGXFER_SEQ -- requirements
Module: regxfer_seq

---
 rtl/regxfer_seq.sv | 176 +++++++++++++++++
 tb/tb_regxfer_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regxfer_seq.sv
// Register-to-register transfer sequencer: drives one source onto a shared bus,
// opens the destination's capture path, strobes its latch, then releases.
module regxfer_seq #(
    parameter  int NREG   = 8,
    parameter  int SETTLE = 1,
    localparam int SW     = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            start,
    input  logic [SW-1:0]   src,
    input  logic [SW-1:0]   dst,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [NREG-1:0] oe,
    output logic [NREG-1:0] hold,
    output logic [NREG-1:0] latch
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_LATCH,
        S_RELEASE
    } state_t;

    localparam logic [SW:0] LP_NREG      = (SW+1)'(NREG);
    localparam logic [3:0]  LP_SETTLE_M1 = 4'(SETTLE - 1);

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt;
    logic [SW-1:0]   r_src, r_dst, w_src_nxt, w_dst_nxt;
    logic            r_buf_valid, w_buf_valid_nxt;
    logic [SW-1:0]   r_buf_src, r_buf_dst, w_buf_src_nxt, w_buf_dst_nxt;

    logic            r_ready, r_busy, r_done, r_err;
    logic [NREG-1:0] r_oe, r_hold, r_latch;
    logic            w_ready_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;
    logic [NREG-1:0] w_oe_nxt, w_hold_nxt, w_latch_nxt;
    logic [NREG-1:0] w_src_sel, w_dst_sel;

    logic            w_accept, w_bad, w_cmd_ok;

    assign w_accept = start & r_ready;
    assign w_bad    = ({1'b0, src} >= LP_NREG) | ({1'b0, dst} >= LP_NREG) | (src == dst);
    assign w_cmd_ok = w_accept & ~w_bad;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_src_nxt       = r_src;
        w_dst_nxt       = r_dst;
        w_buf_valid_nxt = r_buf_valid;
        w_buf_src_nxt   = r_buf_src;
        w_buf_dst_nxt   = r_buf_dst;

        case (r_state)
            S_IDLE: begin
                if (w_cmd_ok) begin
                    w_state_nxt = S_DRIVE;
                    w_src_nxt   = src;
                    w_dst_nxt   = dst;
                    w_cnt_nxt   = LP_SETTLE_M1;
                end
            end
            S_DRIVE: begin
                if (w_cmd_ok) begin
                    w_buf_valid_nxt = 1'b1;
                    w_buf_src_nxt   = src;
                    w_buf_dst_nxt   = dst;
                end
                if (r_cnt == 4'd0) w_state_nxt = S_LATCH;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            S_LATCH: begin
                if (w_cmd_ok) begin
                    w_buf_valid_nxt = 1'b1;
                    w_buf_src_nxt   = src;
                    w_buf_dst_nxt   = dst;
                end
                w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                // A command arriving in RELEASE bypasses the buffer so the bus never idles.
                if (r_buf_valid) begin
                    w_state_nxt     = S_DRIVE;
                    w_src_nxt       = r_buf_src;
                    w_dst_nxt       = r_buf_dst;
                    w_cnt_nxt       = LP_SETTLE_M1;
                    w_buf_valid_nxt = 1'b0;
                end else if (w_cmd_ok) begin
                    w_state_nxt = S_DRIVE;
                    w_src_nxt   = src;
                    w_dst_nxt   = dst;
                    w_cnt_nxt   = LP_SETTLE_M1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered without lag.
    always_comb begin
        w_src_sel   = NREG'(1) << w_src_nxt;
        w_dst_sel   = NREG'(1) << w_dst_nxt;
        w_oe_nxt    = '0;
        w_hold_nxt  = '1;
        w_latch_nxt = '0;
        case (w_state_nxt)
            S_DRIVE: begin
                w_oe_nxt   = w_src_sel;
                w_hold_nxt = ~w_dst_sel;
            end
            S_LATCH: begin
                w_oe_nxt    = w_src_sel;
                w_hold_nxt  = ~w_dst_sel;
                w_latch_nxt = w_dst_sel;
            end
            S_RELEASE: w_oe_nxt = w_src_sel;
            default: ;
        endcase
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_done_nxt  = (w_state_nxt == S_RELEASE);
        w_err_nxt   = w_accept & w_bad;
        w_ready_nxt = ~w_buf_valid_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_src       <= '0;
            r_dst       <= '0;
            r_buf_valid <= 1'b0;
            r_buf_src   <= '0;
            r_buf_dst   <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_oe        <= '0;
            r_hold      <= '1;
            r_latch     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_src       <= w_src_nxt;
            r_dst       <= w_dst_nxt;
            r_buf_valid <= w_buf_valid_nxt;
            r_buf_src   <= w_buf_src_nxt;
            r_buf_dst   <= w_buf_dst_nxt;
            r_ready     <= w_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_oe        <= w_oe_nxt;
            r_hold      <= w_hold_nxt;
            r_latch     <= w_latch_nxt;
        end
    end

    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;
    assign oe    = r_oe;
    assign hold  = r_hold;
    assign latch = r_latch;

endmodule

// File: tb/tb_regxfer_seq.sv
// Bench for regxfer_seq: directed transfers with a done/err scoreboard, plus
// cycle-exact checks of oe/hold/latch for SETTLE=1 and SETTLE=3 instances.
module tb_regxfer_seq;

    typedef struct {
        logic       is_err;
        logic [7:0] oe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [2:0] src = '0, dst = '0;
    logic       ready, busy, done, err;
    logic [7:0] oe, hold, latch;

    logic       start3 = 1'b0;
    logic [2:0] src3 = '0, dst3 = '0;
    logic       ready3, busy3, done3, err3;
    logic [7:0] oe3, hold3, latch3;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    regxfer_seq #(.NREG(8), .SETTLE(1)) u_dut (
        .CLK(clk), .RESET_N(rst_n), .start(start), .src(src), .dst(dst),
        .ready(ready), .busy(busy), .done(done), .err(err),
        .oe(oe), .hold(hold), .latch(latch)
    );

    regxfer_seq #(.NREG(8), .SETTLE(3)) u_dut3 (
        .CLK(clk), .RESET_N(rst_n), .start(start3), .src(src3), .dst(dst3),
        .ready(ready3), .busy(busy3), .done(done3), .err(err3),
        .oe(oe3), .hold(hold3), .latch(latch3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every done/err pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            check("oe_onehot0",    32'($onehot0(oe)),    32'd1);
            check("latch_onehot0", 32'($onehot0(latch)), 32'd1);
            check("busy_vs_oe",    32'(busy),            32'(oe != 8'h00));
            check("oe3_onehot0",   32'($onehot0(oe3)),   32'd1);
            if (done || err) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_out", {30'b0, done, err}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_kind_err", 32'(err), 32'(e.is_err));
                    check("sb_kind_done", 32'(done), 32'(!e.is_err));
                    if (!e.is_err) check("sb_done_oe", 32'(oe), 32'(e.oe));
                end
            end
        end
    end

    initial begin
        // Reset state, asserted before any clock edge
        #1 rst_n = 1'b0;
        #2;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_err",   32'(err),   32'd0);
        check("rst_oe",    32'(oe),    32'h00);
        check("rst_latch", 32'(latch), 32'h00);
        check("rst_hold",  32'(hold),  32'hFF);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single transfer 2->5
        start = 1'b1; src = 3'd2; dst = 3'd5;
        sb.push_back('{1'b0, 8'h04});
        tick();
        start = 1'b0;
        check("t1_c1_oe",    32'(oe),    32'h04);
        check("t1_c1_hold",  32'(hold),  32'hDF);
        check("t1_c1_latch", 32'(latch), 32'h00);
        check("t1_c1_busy",  32'(busy),  32'd1);
        tick();
        check("t1_c2_latch", 32'(latch), 32'h20);
        check("t1_c2_oe",    32'(oe),    32'h04);
        check("t1_c2_hold",  32'(hold),  32'hDF);
        tick();
        check("t1_c3_latch", 32'(latch), 32'h00);
        check("t1_c3_hold",  32'(hold),  32'hFF);
        check("t1_c3_done",  32'(done),  32'd1);
        check("t1_c3_oe",    32'(oe),    32'h04);
        tick();
        check("t1_c4_oe",    32'(oe),    32'h00);
        check("t1_c4_busy",  32'(busy),  32'd0);
        check("t1_c4_done",  32'(done),  32'd0);

        // Reject src==dst
        start = 1'b1; src = 3'd7; dst = 3'd7;
        sb.push_back('{1'b1, 8'h00});
        tick();
        start = 1'b0;
        check("t2_err",   32'(err),   32'd1);
        check("t2_oe",    32'(oe),    32'h00);
        check("t2_hold",  32'(hold),  32'hFF);
        check("t2_latch", 32'(latch), 32'h00);
        check("t2_ready", 32'(ready), 32'd1);
        check("t2_busy",  32'(busy),  32'd0);
        tick();
        check("t2_err_pulse", 32'(err), 32'd0);

        // Back-to-back 3->1 then 4->6
        start = 1'b1; src = 3'd3; dst = 3'd1;
        sb.push_back('{1'b0, 8'h08});
        tick();
        check("t3_ready_before_buf", 32'(ready), 32'd1);
        src = 3'd4; dst = 3'd6;
        sb.push_back('{1'b0, 8'h10});
        tick();
        start = 1'b0;
        check("t3_ready_full", 32'(ready), 32'd0);
        check("t3_latch_a",    32'(latch), 32'h02);
        check("t3_oe_a",       32'(oe),    32'h08);
        tick();
        check("t3_done_a",     32'(done),  32'd1);
        check("t3_oe_rel_a",   32'(oe),    32'h08);
        tick();
        check("t3_oe_switch",  32'(oe),    32'h10);
        check("t3_done_gap",   32'(done),  32'd0);
        check("t3_busy_b",     32'(busy),  32'd1);
        check("t3_ready_drain",32'(ready), 32'd1);
        check("t3_hold_b",     32'(hold),  32'hBF);
        tick();
        check("t3_latch_b",    32'(latch), 32'h40);
        tick();
        check("t3_done_b",     32'(done),  32'd1);
        check("t3_oe_rel_b",   32'(oe),    32'h10);
        tick();
        check("t3_idle_oe",    32'(oe),    32'h00);

        // Full buffer: third start while ready low is ignored
        start = 1'b1; src = 3'd1; dst = 3'd2;
        sb.push_back('{1'b0, 8'h02});
        tick();
        src = 3'd5; dst = 3'd0;
        sb.push_back('{1'b0, 8'h20});
        tick();
        check("t4_ready_full", 32'(ready), 32'd0);
        src = 3'd6; dst = 3'd6;
        tick();
        start = 1'b0;
        check("t4_no_err_a", 32'(err),  32'd0);
        check("t4_done_a",   32'(done), 32'd1);
        tick();
        check("t4_no_err_b", 32'(err),   32'd0);
        check("t4_ready",    32'(ready), 32'd1);
        check("t4_oe_b",     32'(oe),    32'h20);
        repeat (3) tick();
        check("t4_idle", 32'(busy), 32'd0);

        // Reset during LATCH with a command buffered
        start = 1'b1; src = 3'd2; dst = 3'd3;
        tick();
        src = 3'd6; dst = 3'd1;
        tick();
        start = 1'b0;
        check("t5_in_latch", 32'(latch), 32'h08);
        #2 rst_n = 1'b0;
        #1;
        check("t5_latch", 32'(latch), 32'h00);
        check("t5_oe",    32'(oe),    32'h00);
        check("t5_busy",  32'(busy),  32'd0);
        check("t5_done",  32'(done),  32'd0);
        check("t5_hold",  32'(hold),  32'hFF);
        check("t5_ready", 32'(ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        start = 1'b1; src = 3'd0; dst = 3'd4;
        sb.push_back('{1'b0, 8'h01});
        tick();
        start = 1'b0;
        check("t5_post_oe",   32'(oe),   32'h01);
        check("t5_post_hold", 32'(hold), 32'hEF);
        check("t5_post_busy", 32'(busy), 32'd1);
        repeat (3) tick();
        check("t5_post_idle", 32'(busy), 32'd0);

        // SETTLE=3 instance: 0->7
        start3 = 1'b1; src3 = 3'd0; dst3 = 3'd7;
        tick();
        start3 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("t6_c%0d_oe", i),    32'(oe3),    32'h01);
            check($sformatf("t6_c%0d_latch", i), 32'(latch3), (i == 4) ? 32'h80 : 32'h00);
            check($sformatf("t6_c%0d_done", i),  32'(done3),  (i == 5) ? 32'd1 : 32'd0);
            check($sformatf("t6_c%0d_busy", i),  32'(busy3),  32'd1);
            tick();
        end
        check("t6_idle_oe",   32'(oe3),   32'h00);
        check("t6_idle_busy", 32'(busy3), 32'd0);

        repeat (4) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
